intra_filter_acc: RTL and testbench

- Downstream consumer of the per-reference-sample constant-multiplier blocks (MCM stage) in the intra angular predictor.
- Each cycle it takes the four tap products that belong to one predicted sample, one from each MCM lane, and sums them.
- It then adds the rounding offset, shifts, and clips the result to an 8-bit predicted pixel.
- It is a 2-stage valid/ready pipeline with a row-position counter that flags the last sample of each block row for the write-back stage.

---
 rtl/intra_pkg.sv | 9 +
 rtl/intra_round_clip.sv | 37 +++
 rtl/intra_filter_acc.sv | 119 +++++++++++
 tb/tb_intra_filter_acc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared defaults for the intra angular prediction datapath.
package intra_pkg;
  localparam int BLOCK_W   = 16;
  localparam int PROD_W    = 16;
  localparam int SHIFT     = 6;
  localparam int PIX_W     = 8;
  localparam int SUM_W     = PROD_W + 2;
  localparam int ROUND_OFS = 1 << (SHIFT - 1);
endpackage

// File: rtl/intra_round_clip.sv
// Combinational round, arithmetic shift and clip of a filter sum to an unsigned pixel.
// Shared by the angular, planar and DC prediction paths.
module intra_round_clip #(
  parameter int SUM_W = intra_pkg::SUM_W,
  parameter int SHIFT = intra_pkg::SHIFT,
  parameter int PIX_W = intra_pkg::PIX_W
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [PIX_W-1:0] pix,
  output logic                    clipped
);
  import intra_pkg::*;

  localparam logic signed [SUM_W:0] RND = (SUM_W+1)'(1 << (SHIFT - 1));

  // One guard bit so the rounding offset cannot wrap a near-maximum sum.
  function automatic logic signed [SUM_W:0] round_shift(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W:0] t;
    t = (SUM_W+1)'(s) + RND;
    return t >>> SHIFT;
  endfunction

  // Returns {clipped, pixel}.
  function automatic logic [PIX_W:0] saturate(input logic signed [SUM_W:0] r);
    if (r[SUM_W])
      return {1'b1, {PIX_W{1'b0}}};
    else if (|r[SUM_W-1:PIX_W])
      return {1'b1, {PIX_W{1'b1}}};
    else
      return {1'b0, r[PIX_W-1:0]};
  endfunction

  logic signed [SUM_W:0] r;

  assign r              = round_shift(sum);
  assign {clipped, pix} = saturate(r);
endmodule

// File: rtl/intra_filter_acc.sv
// Sums four MCM tap products per predicted sample, rounds/clips to a pixel, flags row ends.
// Optional clipped-output statistics counter: define INTRA_FILTER_CLIP_STATS_EN.
module intra_filter_acc #(
  parameter int BLOCK_W = intra_pkg::BLOCK_W,
  parameter int PROD_W  = intra_pkg::PROD_W,
  parameter int SHIFT   = intra_pkg::SHIFT,
  parameter int PIX_W   = intra_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic signed [PROD_W-1:0] in_p0,
  input  logic signed [PROD_W-1:0] in_p1,
  input  logic signed [PROD_W-1:0] in_p2,
  input  logic signed [PROD_W-1:0] in_p3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [PIX_W-1:0]  out_pix,
  output logic                     out_last
`ifdef INTRA_FILTER_CLIP_STATS_EN
  ,
  input  logic                     clip_clr,
  output logic        [15:0]       clip_cnt
`endif
);
  import intra_pkg::*;

  localparam int SUM_W = PROD_W + 2;
  localparam int CNT_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;

  logic                    vld_p1, vld_p2;
  logic signed [SUM_W-1:0] sum_p1;
  logic                    last_p1, last_p2;
  logic        [PIX_W-1:0] pix_p2;
  logic                    clip_p2;
  logic        [CNT_W-1:0] cnt, idx;
  logic                    last_in, acc, s1_adv, s2_adv;
  logic        [PIX_W-1:0] pix_rc;
  logic                    clip_rc;

  assign s2_adv   = !vld_p2 | out_ready;
  assign s1_adv   = !vld_p1 | s2_adv;
  assign in_ready = s1_adv;
  assign acc      = in_valid & s1_adv;

  // A start-of-block sample is index 0 regardless of where the previous row stopped.
  assign idx     = in_sof ? '0 : cnt;
  assign last_in = (idx == CNT_W'(BLOCK_W - 1));

  // ---- Stage 1: tap sum ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      cnt     <= '0;
    end else begin
      if (s1_adv) begin
        vld_p1 <= in_valid;
        if (in_valid)
          last_p1 <= last_in;
      end
      if (acc)
        cnt <= last_in ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      sum_p1 <= SUM_W'(in_p0) + SUM_W'(in_p1) + SUM_W'(in_p2) + SUM_W'(in_p3);
  end

  intra_round_clip #(
    .SUM_W (SUM_W),
    .SHIFT (SHIFT),
    .PIX_W (PIX_W)
  ) u_round_clip (
    .sum     (sum_p1),
    .pix     (pix_rc),
    .clipped (clip_rc)
  );

  // ---- Stage 2: rounded, clipped pixel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      pix_p2  <= '0;
      last_p2 <= 1'b0;
      clip_p2 <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pix_p2  <= pix_rc;
        last_p2 <= last_p1;
        clip_p2 <= clip_rc;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_pix   = pix_p2;
  assign out_last  = last_p2;

`ifdef INTRA_FILTER_CLIP_STATS_EN
  // Counts clipped pixels as they leave; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_cnt <= '0;
    else if (clip_clr)
      clip_cnt <= '0;
    else if (vld_p2 && out_ready && clip_p2 && (clip_cnt != 16'hFFFF))
      clip_cnt <= clip_cnt + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = clip_p2;
`endif
endmodule

// File: tb/tb_intra_filter_acc.sv
// Scoreboard bench for intra_filter_acc; clip counter checks need INTRA_FILTER_CLIP_STATS_EN.
module tb_intra_filter_acc;
  localparam int BW = 16;

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
    logic       clip;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid, in_ready, in_sof;
  logic signed [15:0] in_p0, in_p1, in_p2, in_p3;
  logic               out_valid, out_ready, out_last;
  logic        [7:0]  out_pix;
  logic               clip_clr;
  logic        [15:0] clip_cnt;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   bidx = 0;
  int   exp_clip = 0;
  int   ready_mode = 0;
  logic       held = 1'b0;
  logic [7:0] hpix;
  logic       hlast;

  intra_filter_acc dut (
`ifdef INTRA_FILTER_CLIP_STATS_EN
    .clip_clr  (clip_clr),
    .clip_cnt  (clip_cnt),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_p0     (in_p0),
    .in_p1     (in_p1),
    .in_p2     (in_p2),
    .in_p3     (in_p3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one sample until accepted; the expected pixel is hand-computed (exp_pix >= 0)
  // or taken from the bench's reference model (exp_pix < 0).
  task automatic send(input logic sof, input int a, input int b, input int c, input int d,
                      input int exp_pix);
    int   s, r, idx, cyc;
    exp_t e;
    s = a + b + c + d;
    r = (s + 32) >>> 6;
    e.clip = (r < 0) || (r > 255);
    if (exp_pix >= 0)      e.pix = 8'(exp_pix);
    else if (r < 0)        e.pix = 8'd0;
    else if (r > 255)      e.pix = 8'd255;
    else                   e.pix = 8'(r);
    in_valid = 1'b1;
    in_sof   = sof;
    in_p0 = 16'(a); in_p1 = 16'(b); in_p2 = 16'(c); in_p3 = 16'(d);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        idx    = sof ? 0 : bidx;
        e.last = (idx == BW - 1);
        bidx   = e.last ? 0 : idx + 1;
        q.push_back(e);
        break;
      end
      cyc++;
      if (cyc > 1000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int c;
    ready_mode = 0;
    c = 0;
    while (q.size() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_pix", int'(out_pix), int'(hpix));
        chk("hold_last", int'(out_last), int'(hlast));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pix", int'(out_pix), int'(e.pix));
          chk("last", int'(out_last), int'(e.last));
          if (e.clip) exp_clip++;
        end
      end
      held  = out_valid && !out_ready;
      hpix  = out_pix;
      hlast = out_last;
    end
  end

  initial begin
    in_valid = 1'b0; in_sof = 1'b0; clip_clr = 1'b0; out_ready = 1'b1;
    in_p0 = '0; in_p1 = '0; in_p2 = '0; in_p3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    send(1'b1, 5300, 1800, 2800, 2000, 186);
    chk("lat_early_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_pix", int'(out_pix), 186);
    send(1'b0, -1000, -1000, -1000, -1000, 0);
    send(1'b0, 8000, 8000, 8000, 8000, 255);
    send(1'b0, 16, 16, 0, 0, 1);
    drain();

    // Full row restarted mid-row by sof, then one sample into the next row.
    for (int i = 0; i <= BW; i++)
      send(i == 0, i * 64, 0, 0, 0, i);
    drain();

    ready_mode = 1;
    for (int k = 0; k < 200; k++)
      send(k == 0, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, -1);
    drain();

    // Both stages full, then reset: everything in flight is discarded.
    ready_mode = 2;
    out_ready  = 1'b0;
    send(1'b0, 100, 100, 100, 100, -1);
    send(1'b0, 200, 200, 200, 200, -1);
    chk("full_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    q.delete();
    bidx     = 0;
    exp_clip = 0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pix", int'(out_pix), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < BW; i++)
      send(1'b0, (i - 8) * 3000, 500, -200, 4000, -1);
    drain();

`ifdef INTRA_FILTER_CLIP_STATS_EN
    chk("clip_cnt", int'(clip_cnt), exp_clip);
    clip_clr = 1'b1;
    @(posedge clk);
    #1;
    clip_clr = 1'b0;
    chk("clip_clr", int'(clip_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end
endmodule
